tlb_walker: RTL and testbench

Hardware page-table walker serving the instruction/data TLB. On a user-mode TLB miss it fetches the page-table entry (PTE) for the faulting virtual page from memory. A valid, accessible PTE is written back into the TLB through the TLB's `tlb_write` / `reg_logic_page` / `reg_physical_page` refill port. Anything else is reported to the pipeline as a page fault.

---
 rtl/tlb_walker_if.sv | 10 +
 rtl/tlb_walker.sv | 145 ++++++++++++++
 tb/tb_tlb_walker.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_walker_if.sv
// Memory read port used by the page-table walker to fetch PTEs.
interface tlb_walker_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/tlb_walker.sv
// Hardware page-table walker: fetches the PTE for a user-mode TLB miss and
// either refills the TLB or reports a page fault.
module tlb_walker #(
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                tlb_miss,
  input  logic                supervisor_mode,
  input  logic [31:0]         fault_addr,
  input  logic [31:0]         ptbr,
  tlb_walker_if.master        mem,
  output logic                tlb_write,
  output logic [31:0]         reg_logic_page,
  output logic [19:0]         reg_physical_page,
  output logic                page_fault,
  output logic [1:0]          fault_cause,
  output logic                walker_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_CHECK  = 3'd2,
    S_REFILL = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [19:0] vpn_r;
  logic [31:0] addr_r;
  logic [7:0]  wait_cnt_r;
  logic        pte_valid_r;
  logic        pte_user_r;
  logic [19:0] ppn_r;
  logic [1:0]  cause_r;
  logic        accept_s;
  logic        timeout_s;

  assign accept_s  = tlb_miss && !supervisor_mode;
  // Fires on the wait cycle whose incremented count would reach TIMEOUT.
  assign timeout_s = (({1'b0, wait_cnt_r} + 9'd1) == TIMEOUT_C);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) state_nxt_s = S_REQ;
          else          state_nxt_s = S_IDLE;
        end
        S_REQ: begin
          if (mem.mem_ack)    state_nxt_s = S_CHECK;
          else if (timeout_s) state_nxt_s = S_FAULT;
          else                state_nxt_s = S_REQ;
        end
        S_CHECK: begin
          if (!pte_valid_r || !pte_user_r) state_nxt_s = S_FAULT;
          else                             state_nxt_s = S_REFILL;
        end
        S_REFILL: state_nxt_s = S_IDLE;
        S_FAULT:  state_nxt_s = S_IDLE;
        default:  state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Control outputs decoded from the state register only.
  always_comb begin
    mem.mem_req = 1'b0;
    tlb_write   = 1'b0;
    page_fault  = 1'b0;
    walker_busy = 1'b1;
    case (state_r)
      S_IDLE:   walker_busy = 1'b0;
      S_REQ:    mem.mem_req = 1'b1;
      S_CHECK:  walker_busy = 1'b1;
      S_REFILL: tlb_write   = 1'b1;
      S_FAULT:  page_fault  = 1'b1;
      default:  walker_busy = 1'b0;
    endcase
  end

  // Walk datapath: VPN/address latch, wait counter, PTE capture, fault cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      vpn_r       <= 20'd0;
      addr_r      <= 32'd0;
      wait_cnt_r  <= 8'd0;
      pte_valid_r <= 1'b0;
      pte_user_r  <= 1'b0;
      ppn_r       <= 20'd0;
      cause_r     <= 2'd0;
    end else if (!flush) begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            vpn_r      <= fault_addr[31:12];
            addr_r     <= ptbr + {10'd0, fault_addr[31:12], 2'b00};
            wait_cnt_r <= 8'd0;
            cause_r    <= 2'd0;
          end
        end
        S_REQ: begin
          if (mem.mem_ack) begin
            pte_valid_r <= mem.mem_rdata[31];
            pte_user_r  <= mem.mem_rdata[30];
            ppn_r       <= mem.mem_rdata[19:0];
          end else if (timeout_s) begin
            cause_r <= 2'd3;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_CHECK: begin
          if (!pte_valid_r)     cause_r <= 2'd1;
          else if (!pte_user_r) cause_r <= 2'd2;
        end
        default: cause_r <= cause_r;
      endcase
    end
  end

  assign mem.mem_addr      = addr_r;
  assign reg_logic_page    = {12'd0, vpn_r};
  assign reg_physical_page = ppn_r;
  assign fault_cause       = cause_r;

endmodule

// File: tb/tb_tlb_walker.sv
// Randomized scoreboard bench for tlb_walker (TIMEOUT = 4) against a
// rule-level reference model.
module tb_tlb_walker;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        tlb_miss = 1'b0;
  logic        supervisor_mode = 1'b0;
  logic [31:0] fault_addr = 32'd0;
  logic [31:0] ptbr = 32'd0;
  logic        tlb_write;
  logic [31:0] reg_logic_page;
  logic [19:0] reg_physical_page;
  logic        page_fault;
  logic [1:0]  fault_cause;
  logic        walker_busy;

  tlb_walker_if mem ();

  tlb_walker #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .flush(flush), .tlb_miss(tlb_miss),
    .supervisor_mode(supervisor_mode), .fault_addr(fault_addr), .ptbr(ptbr),
    .mem(mem), .tlb_write(tlb_write), .reg_logic_page(reg_logic_page),
    .reg_physical_page(reg_physical_page), .page_fault(page_fault),
    .fault_cause(fault_cause), .walker_busy(walker_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          refill;
    logic [31:0] lp;
    logic [19:0] ppn;
    logic [1:0]  cause;
  } resp_t;

  resp_t exp_q[$];
  int    busy_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    busy_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what one walk must produce, derived from the PTE rules.
  function automatic resp_t model(input logic [31:0] fa, input logic [31:0] pte, input int delay);
    resp_t r;
    r.refill = 1'b0;
    r.lp     = fa >> 12;
    r.ppn    = pte[19:0];
    if (delay >= TMO)  r.cause = 2'd3;
    else if (!pte[31]) r.cause = 2'd1;
    else if (!pte[30]) r.cause = 2'd2;
    else begin
      r.cause  = 2'd0;
      r.refill = 1'b1;
    end
    return r;
  endfunction

  // Monitor: pops expectations on each refill/fault strobe and on each busy run end.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (tlb_write || page_fault) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", {30'd0, tlb_write, page_fault}, 32'd0);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          check("tlb_write", {31'd0, tlb_write}, {31'd0, e.refill});
          check("page_fault", {31'd0, page_fault}, {31'd0, !e.refill});
          check("fault_cause", {30'd0, fault_cause}, {30'd0, e.cause});
          if (e.refill) begin
            check("reg_logic_page", reg_logic_page, e.lp);
            check("reg_physical_page", {12'd0, reg_physical_page}, {12'd0, e.ppn});
          end
        end
      end
      if (walker_busy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (busy_q.size() == 0) check("unexpected_busy_run", busy_run, 0);
        else check("busy_cycles", busy_run, busy_q.pop_front());
        busy_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (walker_busy && guard < 20) begin
      tick();
      guard++;
    end
    if (walker_busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, {31'd0, mem.mem_req}, 32'd0);
    check({tag, "_mem_addr"}, mem.mem_addr, 32'd0);
    check({tag, "_tlb_write"}, {31'd0, tlb_write}, 32'd0);
    check({tag, "_logic_page"}, reg_logic_page, 32'd0);
    check({tag, "_phys_page"}, {12'd0, reg_physical_page}, 32'd0);
    check({tag, "_page_fault"}, {31'd0, page_fault}, 32'd0);
    check({tag, "_fault_cause"}, {30'd0, fault_cause}, 32'd0);
    check({tag, "_busy"}, {31'd0, walker_busy}, 32'd0);
  endtask

  // One complete walk; delay >= TMO means the memory never answers.
  task automatic walk(input logic [31:0] fa, input logic [31:0] pt, input int delay, input logic [31:0] pte);
    resp_t e;
    e = model(fa, pte, delay);
    exp_q.push_back(e);
    busy_q.push_back((delay >= TMO) ? TMO + 1 : delay + 3);
    fault_addr = fa;
    ptbr       = pt;
    tlb_miss   = 1'b1;
    tick();
    tlb_miss   = 1'b0;
    check("mem_req_after_miss", {31'd0, mem.mem_req}, 32'd1);
    check("mem_addr", mem.mem_addr, pt + (fa >> 12) * 4);
    for (int i = 0; i < delay && i < TMO; i++) begin
      check("mem_req_held", {31'd0, mem.mem_req}, 32'd1);
      mem.mem_rdata = $urandom;
      tick();
    end
    if (delay < TMO) begin
      mem.mem_ack   = 1'b1;
      mem.mem_rdata = pte;
      tick();
      mem.mem_ack   = 1'b0;
    end else begin
      check("mem_req_drop_timeout", {31'd0, mem.mem_req}, 32'd0);
    end
    wait_idle();
    check("cause_held", {30'd0, fault_cause}, {30'd0, e.cause});
  endtask

  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = 32'd0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Directed cases: refill, invalid, protection, timeout + stray ack.
    walk(32'h0040_3ABC, 32'h0001_0000, 2, 32'hC000_0123);
    walk(32'h1234_5678, 32'h0002_0000, 0, 32'h4000_0055);
    walk(32'h8765_4321, 32'h0003_0000, 1, 32'h8000_0055);
    walk(32'hFFFF_F000, 32'hFFFF_FFF0, TMO, 32'hC000_0001);
    mem.mem_ack = 1'b1;
    tick();
    mem.mem_ack = 1'b0;
    check("stray_ack_no_req", {31'd0, mem.mem_req}, 32'd0);
    check("stray_ack_idle", {31'd0, walker_busy}, 32'd0);

    // Flush in the second REQ cycle, ack arrives afterwards.
    busy_q.push_back(2);
    fault_addr = 32'h0ABC_D000;
    tlb_miss   = 1'b1;
    tick();
    tlb_miss   = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_req_drop", {31'd0, mem.mem_req}, 32'd0);
    check("flush_busy_drop", {31'd0, walker_busy}, 32'd0);
    check("flush_cause_kept", {30'd0, fault_cause}, 32'd0);
    mem.mem_ack   = 1'b1;
    mem.mem_rdata = 32'hC000_0777;
    tick();
    mem.mem_ack = 1'b0;
    repeat (2) tick();

    // Supervisor-mode miss is ignored.
    supervisor_mode = 1'b1;
    tlb_miss        = 1'b1;
    repeat (2) begin
      tick();
      check("super_no_req", {31'd0, mem.mem_req}, 32'd0);
    end
    tlb_miss        = 1'b0;
    supervisor_mode = 1'b0;
    tick();

    // Reset asserted while in CHECK.
    fault_addr = 32'h5555_5000;
    tlb_miss   = 1'b1;
    tick();
    tlb_miss      = 1'b0;
    mem.mem_ack   = 1'b1;
    mem.mem_rdata = 32'hC000_0AAA;
    tick();
    mem.mem_ack = 1'b0;
    reset       = 1'b1;
    tick();
    check_reset_outputs("rst_check");
    reset = 1'b0;
    tick();

    // Randomized back-to-back walks.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] pte;
      pte = $urandom;
      walk($urandom, $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 5)), pte);
    end

    repeat (4) tick();
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("busy_q_drained", busy_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
